// File: rtl/w_debounce_pkg.sv
// Shared types and constants for the w debouncer.
//   state_t            : 2-bit debouncer FSM state encoding
//   STABLE_CYCLES_DEF  : default qualification length in sampled cycles
package w_debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        CHK_HI  = 2'b01,
        IDLE_HI = 2'b10,
        CHK_LO  = 2'b11
    } state_t;

endpackage

// File: rtl/w_debounce_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : sampling clock
//   reset : synchronous, active-high; clears both flops
//   d     : asynchronous input level
//   q     : synchronized level, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w_debounce.sv
// Debouncer producing the clean w level and its edge pulses for the
// downstream sequence detector.
// Optional feature: define W_DEBOUNCE_SYNC_EN to put a two-flop
// synchronizer (sync_2ff) in front of the FSM; otherwise raw_in is used
// directly and acceptance happens two edges earlier.
//   clk    : clock, all flops on rising edge
//   reset  : synchronous, active-high
//   raw_in : noisy asynchronous input level
//   w      : debounced level
//   w_rise : one-cycle pulse when w goes 0->1
//   w_fall : one-cycle pulse when w goes 1->0
//   busy   : high while a level change is being qualified
module w_debounce
    import w_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic w,
    output logic w_rise,
    output logic w_fall,
    output logic busy
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          w_nxt, w_rise_nxt, w_fall_nxt;

`ifdef W_DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );
`else
    assign s = raw_in;
`endif

    // State and output registers; reset wins over any pending acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            w      <= 1'b0;
            w_rise <= 1'b0;
            w_fall <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            w      <= w_nxt;
            w_rise <= w_rise_nxt;
            w_fall <= w_fall_nxt;
            busy   <= (state_nxt == CHK_HI) || (state_nxt == CHK_LO);
        end
    end

    // Next-state: a candidate level must be seen STABLE_CYCLES edges in a
    // row (counting the entry edge) before w follows it.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        w_nxt      = w;
        w_rise_nxt = 1'b0;
        w_fall_nxt = 1'b0;
        unique case (state)
            IDLE_LO: begin
                if (s) begin
                    state_nxt = CHK_HI;
                    cnt_nxt   = CW'(1);
                end
            end
            CHK_HI: begin
                if (!s) begin
                    state_nxt = IDLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE_HI;
                    cnt_nxt    = '0;
                    w_nxt      = 1'b1;
                    w_rise_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            IDLE_HI: begin
                if (!s) begin
                    state_nxt = CHK_LO;
                    cnt_nxt   = CW'(1);
                end
            end
            CHK_LO: begin
                if (s) begin
                    state_nxt = IDLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE_LO;
                    cnt_nxt    = '0;
                    w_nxt      = 1'b0;
                    w_fall_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_w_debounce.sv
// Directed self-checking bench for w_debounce (STABLE_CYCLES = 4).
// Works with or without W_DEBOUNCE_SYNC_EN; the synchronizer adds two edges.
module tb_w_debounce;

    localparam int unsigned N = 4;
`ifdef W_DEBOUNCE_SYNC_EN
    localparam int unsigned SYNC = 2;
`else
    localparam int unsigned SYNC = 0;
`endif
    // Edges from first drive of a new level to the w update (inclusive).
    localparam int unsigned L = N - 1 + SYNC + 1;

    logic clk = 1'b0;
    logic reset;
    logic raw_in;
    logic w, w_rise, w_fall, busy;

    int checks = 0;
    int errors = 0;

    w_debounce #(.STABLE_CYCLES(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_in (raw_in),
        .w      (w),
        .w_rise (w_rise),
        .w_fall (w_fall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int rises, falls, busy_cyc, rise_at;
    logic bounce [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        reset  = 1'b1;
        raw_in = 1'b0;
        step(3);
        check("rst_w", 32'(w), 0);
        check("rst_rise", 32'(w_rise), 0);
        check("rst_fall", 32'(w_fall), 0);
        check("rst_busy", 32'(busy), 0);

        // Clean rise: w follows on the L-th edge after raw_in goes high.
        reset  = 1'b0;
        raw_in = 1'b1;
        step(L - 1);
        check("rise_pre_w", 32'(w), 0);
        check("rise_pre_busy", 32'(busy), 1);
        step(1);
        check("rise_w", 32'(w), 1);
        check("rise_pulse", 32'(w_rise), 1);
        check("rise_nofall", 32'(w_fall), 0);
        check("rise_busy", 32'(busy), 0);
        step(1);
        check("rise_pulse_end", 32'(w_rise), 0);
        check("rise_hold_w", 32'(w), 1);

        // Clean fall.
        raw_in = 1'b0;
        step(L - 1);
        check("fall_pre_w", 32'(w), 1);
        step(1);
        check("fall_w", 32'(w), 0);
        check("fall_pulse", 32'(w_fall), 1);
        check("fall_norise", 32'(w_rise), 0);
        step(1);
        check("fall_pulse_end", 32'(w_fall), 0);

        // Short pulse of 3 samples: rejected, busy high for exactly 3 cycles.
        rises = 0; busy_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            raw_in = (i < 3);
            step(1);
            if (w_rise) rises++;
            if (busy) busy_cyc++;
        end
        check("glitch_w", 32'(w), 0);
        check("glitch_rises", 32'(rises), 0);
        check("glitch_busy", 32'(busy_cyc), 3);

        // Bounce 1,0,1,1,1,1 then hold: one rise, L edges after the final 0->1.
        rises = 0; rise_at = -1;
        for (int i = 0; i < 16; i++) begin
            raw_in = (i < 6) ? bounce[i] : 1'b1;
            step(1);
            if (w_rise) begin
                rises++;
                rise_at = i;
            end
        end
        check("bounce_rises", 32'(rises), 1);
        check("bounce_at", 32'(rise_at), 32'(2 + L - 1));
        check("bounce_w", 32'(w), 1);

        // Return low for the reset test.
        falls = 0;
        for (int i = 0; i < int'(L) + 2; i++) begin
            raw_in = 1'b0;
            step(1);
            if (w_fall) falls++;
        end
        check("ret_falls", 32'(falls), 1);
        check("ret_w", 32'(w), 0);

        // Reset on the accepting edge: pending rise dropped.
        raw_in = 1'b1;
        step(L - 1);
        reset = 1'b1;
        step(1);
        check("rstacc_w", 32'(w), 0);
        check("rstacc_rise", 32'(w_rise), 0);
        check("rstacc_busy", 32'(busy), 0);
        check("rstacc_state", 32'(dut.state), 0);

        // Held-high input after reset release qualifies as a fresh rise.
        reset = 1'b0;
        step(L - 1);
        check("fresh_pre_w", 32'(w), 0);
        step(1);
        check("fresh_w", 32'(w), 1);
        check("fresh_rise", 32'(w_rise), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
